pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a classic five-stage pipeline
// (IF/ID/EX/MEM/WB). It produces the PC write enable and the enable/flush pair
// of every pipeline register from three hazard sources:
//   * ex_branch_taken   : control hazard, squash the two younger stages
//   * mul/div occupancy : multi-cycle EX, freeze IF..EX and bubble EX/MEM
//   * load_use          : one-cycle interlock for a load feeding ID
// An external hold freezes everything, including the mul/div sequencer.
//
// Priority: hold > ex_branch_taken > mul/div stall > load_use.
// A pipeline register only honours flush while its enable is 1, so every
// bubble is driven as we=1, flush=1.
//
// All state updates on the falling edge of Clk, the same edge the pipeline
// registers use. Rst is asynchronous and active-high; while it is asserted
// every enable and flush is 0.
//
// Parameters
//   MD_CYCLES   total EX occupancy of a mul/div instruction, legal 2..16.
//               The pipeline is stalled for MD_CYCLES-1 cycles.
//
// Configuration macro
//   PIPE_HAZARD_PERF_EN  when defined, stall_cycles / flush_events are live
//                        32-bit wrapping counters; otherwise both ports are
//                        tied to 0 and no counter flops exist.
//
// Ports
//   Clk, Rst                 clock (falling edge active), async reset
//   hold                     external freeze (e.g. memory wait)
//   id_rs, id_rt             source registers of the instruction in ID
//   id_uses_rs, id_uses_rt   source-valid flags
//   ex_mem_read, ex_rt       instruction in EX is a load, and its destination
//   ex_branch_taken          branch/jump resolved taken in EX
//   md_start                 mul/div instruction present in EX
//   pc_we                    PC write enable
//   {ifid,idex,exmem,memwb}_{we,flush}  pipeline register controls
//   md_busy                  mul/div sequencer not idle
//   md_done                  final cycle of a mul/div instruction
//   stall_cycles             cycles with pc_we=0 outside hold
//   flush_events             taken branches outside hold
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        hold,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        md_start,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_flush,
  output logic        exmem_we,
  output logic        exmem_flush,
  output logic        memwb_we,
  output logic        memwb_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Counter value loaded on entry to BUSY: the start cycle itself is the
  // first stall cycle, so BUSY covers the remaining MD_CYCLES-1 cycles and
  // the last one (cnt==1) is the release cycle that raises md_done.
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic md_stall;
  logic md_last;
  logic load_use;

  // ---------------------------------------------------------------------------
  // Mul/div sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the next-state logic below uses blocking ones.
  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div sequencer: next state and stall request
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_last  = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        // A taken branch squashes the mul/div in EX, so it never starts.
        if (md_start && !ex_branch_taken) begin
          md_stall = 1'b1;
          if (!hold) begin
            state_d = MD_BUSY;
            cnt_d   = MD_LOAD;
          end
        end
      end

      MD_BUSY: begin
        if (cnt_q > 4'd1) begin
          md_stall = 1'b1;
          if (!hold) begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          // Release cycle: md_start still shows the same instruction in EX
          // and must not retrigger the sequencer.
          md_last = 1'b1;
          if (!hold) begin
            state_d = MD_IDLE;
            cnt_d   = 4'd0;
          end
        end
      end

      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);
  // A frozen release cycle is not the final cycle yet; it completes once
  // hold drops.
  assign md_done = md_last && !hold && !Rst;

  // ---------------------------------------------------------------------------
  // Load-use detection. A load into $0 never creates a dependency.
  // ---------------------------------------------------------------------------
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  // ---------------------------------------------------------------------------
  // Pipeline control, strict priority. A load_use masked by an md stall is
  // simply seen again on the release cycle, since the inputs are still there.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;

    if (Rst || hold) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (ex_branch_taken) begin
      // Squash the wrong-path instructions in IF/ID and ID/EX.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_stall) begin
      // Freeze IF..EX around the busy mul/div and bubble into MEM.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, insert one bubble into EX.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both wrap naturally modulo 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      if (!pc_we) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (ex_branch_taken) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (MD_CYCLES=4). Inputs are driven just
// after the falling edge (the active edge), outputs are checked on the rising
// edge. Control outputs are compared as one packed vector:
//   {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
//    exmem_we, exmem_flush, memwb_we, memwb_flush}
// Expected counter values are tracked from the expected control patterns.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] CTL_ZERO = 9'b000_000_000;
  localparam logic [8:0] CTL_DEF  = 9'b110_101_010;
  localparam logic [8:0] CTL_LU   = 9'b000_111_010;
  localparam logic [8:0] CTL_BR   = 9'b111_111_010;
  localparam logic [8:0] CTL_MD   = 9'b000_001_110;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        Clk;
  logic        Rst;
  logic        hold;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        md_start;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic        exmem_we, exmem_flush, memwb_we, memwb_flush;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles, flush_events;

  logic [8:0]  ctl;
  int          n_checks;
  int          n_errors;
  int unsigned exp_stall;
  int unsigned exp_flush;

  pipe_hazard_ctrl #(.MD_CYCLES(4)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .hold            (hold),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .md_start        (md_start),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_we         (idex_we),
    .idex_flush      (idex_flush),
    .exmem_we        (exmem_we),
    .exmem_flush     (exmem_flush),
    .memwb_we        (memwb_we),
    .memwb_flush     (memwb_flush),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  assign ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                exmem_we, exmem_flush, memwb_we, memwb_flush};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    hold            = 1'b0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    ex_branch_taken = 1'b0;
    md_start        = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    ex_mem_read = 1'b1;
    ex_rt       = rt;
    id_rs       = rt;
    id_uses_rs  = 1'b1;
  endtask

  // Check one cycle on the rising edge, advance the counter model for the
  // coming falling edge, then move to just after that edge.
  task automatic step(input string tag, input logic [8:0] exp_ctl,
                      input logic exp_busy, input logic exp_done);
    @(posedge Clk);
    check({tag, "_ctl"},   32'(ctl),     32'(exp_ctl));
    check({tag, "_busy"},  32'(md_busy), 32'(exp_busy));
    check({tag, "_done"},  32'(md_done), 32'(exp_done));
    check({tag, "_stall"}, stall_cycles, PERF_EN ? exp_stall : 32'd0);
    check({tag, "_flush"}, flush_events, PERF_EN ? exp_flush : 32'd0);
    if (Rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else if (!hold) begin
      if (!exp_ctl[8])     exp_stall++;
      if (ex_branch_taken) exp_flush++;
    end
    @(negedge Clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_stall = 0;
    exp_flush = 0;
    clr_inputs();

    // Reset: everything off even with hazard inputs active.
    Rst             = 1'b1;
    ex_branch_taken = 1'b1;
    md_start        = 1'b1;
    step("rst", CTL_ZERO, 1'b0, 1'b0);
    Rst = 1'b0;
    clr_inputs();

    step("idle", CTL_DEF, 1'b0, 1'b0);

    // Load-use on rs: exactly one interlock cycle.
    set_load_use(5'd5);
    step("lu_rs", CTL_LU, 1'b0, 1'b0);
    clr_inputs();
    step("lu_after", CTL_DEF, 1'b0, 1'b0);

    // Load-use on rt.
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
    step("lu_rt", CTL_LU, 1'b0, 1'b0);
    // Same registers but the source is not used.
    id_uses_rt = 1'b0; id_uses_rs = 1'b1;
    step("lu_unused", CTL_DEF, 1'b0, 1'b0);
    // Load into $0 is never a hazard.
    ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    step("lu_zero", CTL_DEF, 1'b0, 1'b0);
    clr_inputs();

    // Branch beats a simultaneous load_use.
    set_load_use(5'd5);
    ex_branch_taken = 1'b1;
    step("br_lu", CTL_BR, 1'b0, 1'b0);
    clr_inputs();

    // Mul/div, md_start held in EX for all four cycles.
    md_start = 1'b1;
    step("md0", CTL_MD,  1'b0, 1'b0);
    step("md1", CTL_MD,  1'b1, 1'b0);
    step("md2", CTL_MD,  1'b1, 1'b0);
    step("md3", CTL_DEF, 1'b1, 1'b1);
    md_start = 1'b0;
    step("md_end", CTL_DEF, 1'b0, 1'b0);

    // Load-use masked by the md stall, then seen on the release cycle.
    md_start = 1'b1;
    step("mlu0", CTL_MD, 1'b0, 1'b0);
    set_load_use(5'd9);
    step("mlu1", CTL_MD, 1'b1, 1'b0);
    step("mlu2", CTL_MD, 1'b1, 1'b0);
    step("mlu3", CTL_LU, 1'b1, 1'b1);
    clr_inputs();
    step("mlu_end", CTL_DEF, 1'b0, 1'b0);

    // Hold for two cycles with cnt=2: frozen, then one stall, then done.
    md_start = 1'b1;
    step("hd0", CTL_MD, 1'b0, 1'b0);
    step("hd1", CTL_MD, 1'b1, 1'b0);
    hold = 1'b1;
    step("hd_hold0", CTL_ZERO, 1'b1, 1'b0);
    step("hd_hold1", CTL_ZERO, 1'b1, 1'b0);
    hold = 1'b0;
    step("hd2", CTL_MD,  1'b1, 1'b0);
    step("hd3", CTL_DEF, 1'b1, 1'b1);
    md_start = 1'b0;
    step("hd_end", CTL_DEF, 1'b0, 1'b0);

    // Hold beats a branch and does not count it.
    hold = 1'b1; ex_branch_taken = 1'b1;
    step("hold_br", CTL_ZERO, 1'b0, 1'b0);
    clr_inputs();

    // Illegal branch + md_start: branch wins, sequencer stays idle.
    ex_branch_taken = 1'b1; md_start = 1'b1;
    step("br_md", CTL_BR, 1'b0, 1'b0);
    clr_inputs();
    step("br_md_after", CTL_DEF, 1'b0, 1'b0);

    // Reset pulse in the middle of BUSY aborts the operation.
    md_start = 1'b1;
    step("rb0", CTL_MD, 1'b0, 1'b0);
    step("rb1", CTL_MD, 1'b1, 1'b0);
    Rst = 1'b1;
    step("rb_rst", CTL_ZERO, 1'b0, 1'b0);
    Rst = 1'b0;
    clr_inputs();
    step("rb_after", CTL_DEF, 1'b0, 1'b0);
    step("rb_idle", CTL_DEF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
